// File: rtl/pmc2_core.sv
// pmc2_core: small 36-bit-word microcontroller with a host-loaded program RAM, an external data bus and an optional call stack (PMC2_CALLSTACK_EN)
module pmc2_core #(
    parameter int DATA_W      = 16,
    parameter int PROG_DEPTH  = 64,
    parameter int NREGS       = 8,
    parameter int EA_W        = 13,
    parameter int STACK_DEPTH = 4
) (
    input  logic              pin_M12,
    input  logic              pin_RST,
    input  logic              host_we,
    input  logic              host_sel,
    input  logic [7:0]        host_d,
    input  logic              pin_START,
    output logic              pin_BUSY,
    output logic              pin_ERR,
    output logic              pin_OUT0,
    output logic [EA_W-1:0]   pin_EA,
    input  logic [DATA_W-1:0] pin_ED_I,
    output logic [DATA_W-1:0] pin_ED_O,
    output logic              pin_EROE,
    output logic              pin_ERWE
);
    localparam int PC_W = $clog2(PROG_DEPTH);
    localparam logic [3:0] OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                           OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_SHR = 4'h7,
                           OP_SHL = 4'h8, OP_LD = 4'h9, OP_ST = 4'hA, OP_JMP = 4'hB,
                           OP_JZ = 4'hC, OP_CALL = 4'hD, OP_RET = 4'hE, OP_HALT = 4'hF;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEMRD, HALT} state_t;

    state_t              state, state_nx;
    logic [35:0]         ram [PROG_DEPTH];
    logic [35:0]         ir, ram_q;
    logic [PC_W-1:0]     pc, ld, pc_inc, pc_nx;
    logic [2:0]          cnt;
    logic [27:0]         wbuf;
    logic [DATA_W-1:0]   regs [8];
    logic [DATA_W-1:0]   rd_v, rs_v, f_rd_v, f_rs_v, res;
    logic [DATA_W:0]     sum, diff;
    logic                z, c, c_nx, start_q, out0, fault, rd_ok, alu_op, ram_we;
    logic [EA_W-1:0]     ea;
    logic [DATA_W-1:0]   ed_o;
    logic [3:0]          op;
    logic [2:0]          rd_i, rs_i;
    logic [15:0]         imm;
    logic                unused_bits;

    assign op          = ir[35:32];
    assign rd_i        = ir[31:29];
    assign rs_i        = ir[28:26];
    assign imm         = ir[15:0];
    assign unused_bits = ^ir[25:16];
    assign ram_q       = ram[pc];

    // Registers beyond NREGS read as zero and never accept writes.
    assign rd_ok  = int'(rd_i) < NREGS;
    assign rd_v   = rd_ok ? regs[rd_i] : '0;
    assign rs_v   = (int'(rs_i) < NREGS) ? regs[rs_i] : '0;
    assign f_rd_v = (int'(ram_q[31:29]) < NREGS) ? regs[ram_q[31:29]] : '0;
    assign f_rs_v = (int'(ram_q[28:26]) < NREGS) ? regs[ram_q[28:26]] : '0;
    assign alu_op = op >= OP_ADD && op <= OP_SHL;
    assign ram_we = !pin_BUSY && host_we && host_sel && cnt == 3'd4;

    assign pin_BUSY = state == FETCH || state == EXEC || state == MEMRD;
    assign pin_EROE = !((state == EXEC && op == OP_LD) || state == MEMRD);
    assign pin_ERWE = !(state == EXEC && op == OP_ST);
    assign pin_EA   = ea;
    assign pin_ED_O = ed_o;
    assign pin_OUT0 = out0;

`ifdef PMC2_CALLSTACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    logic [PC_W-1:0] stack [2**SW];
    logic [SP_W-1:0] sp, sp_dec;
    logic            err, push;
    assign sp_dec  = sp - 1'b1;
    assign fault   = state == EXEC && ((op == OP_CALL && int'(sp) == STACK_DEPTH) || (op == OP_RET && sp == '0));
    assign push    = pin_START && state == EXEC && op == OP_CALL && !fault;
    assign pin_ERR = err;
    // Return-address storage; contents need no reset since sp gates every read.
    always_ff @(posedge pin_M12)
        if (push) stack[sp[SW-1:0]] <= pc_inc;
`else
    assign fault   = 1'b0;
    assign pin_ERR = 1'b0;
`endif

    // Program RAM is written only by the host and survives reset.
    always_ff @(posedge pin_M12)
        if (ram_we) ram[ld] <= {wbuf, host_d};

    // ALU: result and carry for ops 2..8; C is the no-borrow bit on SUB.
    always_comb begin
        sum  = {1'b0, rd_v} + {1'b0, rs_v};
        diff = {1'b0, rd_v} - {1'b0, rs_v};
        res  = rd_v;
        c_nx = c;
        case (op)
            OP_ADD: {c_nx, res} = sum;
            OP_SUB: {c_nx, res} = {~diff[DATA_W], diff[DATA_W-1:0]};
            OP_AND: {c_nx, res} = {1'b0, rd_v & rs_v};
            OP_OR:  {c_nx, res} = {1'b0, rd_v | rs_v};
            OP_XOR: {c_nx, res} = {1'b0, rd_v ^ rs_v};
            OP_SHR: {c_nx, res} = {rd_v[0], c, rd_v[DATA_W-1:1]};
            OP_SHL: {c_nx, res} = {rd_v[DATA_W-1], rd_v[DATA_W-2:0], c};
            default: ;
        endcase
    end

    // Next PC after an EXEC: branch target, stack pop, or sequential with wrap.
    always_comb begin
        pc_inc = pc + 1'b1;
        pc_nx  = (op == OP_JMP || (op == OP_JZ && z)) ? PC_W'(imm) : pc_inc;
`ifdef PMC2_CALLSTACK_EN
        if (op == OP_CALL) pc_nx = PC_W'(imm);
        if (op == OP_RET) pc_nx = stack[sp_dec[SW-1:0]];
`endif
    end

    // Next-state logic; dropping START always returns to IDLE.
    always_comb begin
        state_nx = state;
        if (!pin_START)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = start_q ? IDLE : FETCH;
                FETCH:   state_nx = EXEC;
                EXEC:    state_nx = (op == OP_HALT || fault) ? HALT : (op == OP_LD) ? MEMRD : FETCH;
                MEMRD:   state_nx = FETCH;
                default: state_nx = HALT;
            endcase
    end

    // State, datapath and host-loader registers.
    always_ff @(posedge pin_M12 or negedge pin_RST) begin
        if (!pin_RST) begin
            state   <= IDLE;
            pc      <= '0;
            ld      <= '0;
            cnt     <= '0;
            wbuf    <= '0;
            ir      <= '0;
            z       <= 1'b0;
            c       <= 1'b0;
            start_q <= 1'b0;
            out0    <= 1'b1;
            ea      <= '0;
            ed_o    <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
`ifdef PMC2_CALLSTACK_EN
            sp      <= '0;
            err     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            start_q <= pin_START;
            if (!pin_START) out0 <= 1'b1;
            if (!pin_BUSY && host_we) begin
                if (!host_sel) begin
                    ld  <= host_d[PC_W-1:0];
                    cnt <= '0;
                end else if (cnt == 3'd4) begin
                    ld  <= ld + 1'b1;
                    cnt <= '0;
                end else begin
                    wbuf <= {wbuf[19:0], host_d};
                    cnt  <= cnt + 3'd1;
                end
            end
            if (pin_START)
                case (state)
                    IDLE: if (!start_q) pc <= '0;
                    FETCH: begin
                        ir <= ram_q;
                        if (ram_q[35:32] == OP_LD || ram_q[35:32] == OP_ST) ea <= EA_W'(f_rs_v);
                        if (ram_q[35:32] == OP_ST) ed_o <= f_rd_v;
                    end
                    EXEC: begin
                        if (!fault) pc <= pc_nx;
                        if (op == OP_NOP && imm[15]) out0 <= imm[0];
                        if (alu_op) begin
                            z <= res == '0;
                            c <= c_nx;
                        end
                        if ((alu_op || op == OP_LDI) && rd_ok) regs[rd_i] <= (op == OP_LDI) ? DATA_W'(imm) : res;
`ifdef PMC2_CALLSTACK_EN
                        if (fault) err <= 1'b1;
                        else if (op == OP_CALL) sp <= sp + 1'b1;
                        else if (op == OP_RET) sp <= sp_dec;
`endif
                    end
                    MEMRD: if (rd_ok) regs[rd_i] <= pin_ED_I;
                    default: ;
                endcase
        end
    end
endmodule

// File: tb/tb_pmc2_core.sv
// tb_pmc2_core: directed, table-driven bench for pmc2_core with a small external RAM model
module tb_pmc2_core;
    logic        clk = 0, rst_n = 0, host_we = 0, host_sel = 0, start = 0;
    logic [7:0]  host_d = 0;
    logic        busy, err, out0, eroe, erwe;
    logic [12:0] ea;
    logic [15:0] ed_i, ed_o;

    pmc2_core dut (
        .pin_M12(clk), .pin_RST(rst_n), .host_we(host_we), .host_sel(host_sel), .host_d(host_d),
        .pin_START(start), .pin_BUSY(busy), .pin_ERR(err), .pin_OUT0(out0), .pin_EA(ea),
        .pin_ED_I(ed_i), .pin_ED_O(ed_o), .pin_EROE(eroe), .pin_ERWE(erwe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] res;
        logic        z, c;
    } vec_t;

    vec_t        vt [12];
    logic [35:0] pbuf [16];
    logic [15:0] ext_mem [8192];
    int          n_cmp = 0, n_bad = 0, we_cnt = 0, oe_cnt = 0;
    logic [12:0] we_ea;
    logic [15:0] we_d;
    int          bcnt, we0, oe0;
    logic        ok, out0_halt;

    // External RAM model: address 0x0100 is a fixed pattern, others hold what was stored.
    assign ed_i = (ea == 13'h0100) ? 16'h5A5A : ext_mem[ea];

    always @(negedge clk) begin
        if (!erwe) begin
            we_cnt++;
            we_ea = ea;
            we_d  = ed_o;
            ext_mem[ea] = ed_o;
        end
        if (!eroe) oe_cnt++;
    end

    function automatic logic [35:0] ins(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [15:0] imm);
        return {op, rd, rs, 10'b0, imm};
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic host_byte(input logic sel, input logic [7:0] d);
        host_we = 1; host_sel = sel; host_d = d;
        @(negedge clk);
        host_we = 0;
    endtask

    task automatic load_prog(input logic [7:0] addr, input int n);
        host_byte(0, addr);
        for (int i = 0; i < n; i++) begin
            host_byte(1, {4'b0, pbuf[i][35:32]});
            host_byte(1, pbuf[i][31:24]);
            host_byte(1, pbuf[i][23:16]);
            host_byte(1, pbuf[i][15:8]);
            host_byte(1, pbuf[i][7:0]);
        end
    endtask

    // Raise START, count BUSY cycles until the core halts, then drop START.
    task automatic run(input string name);
        start = 1; bcnt = 0; ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
            bcnt++;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout, busy still %b want 0", name, busy);
        end
        out0_halt = out0;
        start = 0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{4'h2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[1]  = '{4'h3, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vt[2]  = '{4'h3, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b1};
        vt[3]  = '{4'h3, 16'h0003, 16'h0003, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[4]  = '{4'h2, 16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0, 1'b0};
        vt[5]  = '{4'h4, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0, 1'b0};
        vt[6]  = '{4'h5, 16'hF000, 16'h000F, 1'b1, 16'hF00F, 1'b0, 1'b0};
        vt[7]  = '{4'h6, 16'hAAAA, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{4'h7, 16'h0003, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b1};
        vt[9]  = '{4'h7, 16'h0002, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0};
        vt[10] = '{4'h8, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[11] = '{4'h8, 16'h4001, 16'h0000, 1'b1, 16'h8003, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out0", out0, 1);
        rst_n = 1;
        @(negedge clk);
        chk("rst_err", err, 0);
        chk("rst_eroe", eroe, 1);
        chk("rst_erwe", erwe, 1);
        chk("rst_ea", ea, 0);
        chk("rst_ed_o", ed_o, 0);

        pbuf[0] = ins(4'h1, 1, 0, 16'h1234);
        pbuf[1] = ins(4'hF, 0, 0, 0);
        load_prog(0, 2);
        run("ldi_halt");
        chk("ldi_busy_cycles", bcnt, 4);
        chk("ldi_r1", dut.regs[1], 16'h1234);

        for (int k = 0; k < 12; k++) begin
            pbuf[0] = ins(4'h1, 1, 0, vt[k].a);
            pbuf[1] = ins(4'h1, 2, 0, vt[k].b);
            pbuf[2] = ins(4'h1, 6, 0, vt[k].cin ? 16'h8000 : 16'h0000);
            pbuf[3] = ins(4'h2, 6, 6, 0);
            pbuf[4] = ins(vt[k].op, 1, 2, 0);
            pbuf[5] = ins(4'hF, 0, 0, 0);
            load_prog(0, 6);
            run($sformatf("alu%0d", k));
            chk($sformatf("alu%0d_res", k), dut.regs[1], vt[k].res);
            chk($sformatf("alu%0d_z", k), dut.z, vt[k].z);
            chk($sformatf("alu%0d_c", k), dut.c, vt[k].c);
        end

        pbuf[0] = ins(4'h1, 3, 0, 16'hBEEF);
        pbuf[1] = ins(4'h1, 5, 0, 16'h0ABC);
        pbuf[2] = ins(4'hA, 3, 5, 0);
        pbuf[3] = ins(4'h9, 4, 5, 0);
        pbuf[4] = ins(4'h1, 7, 0, 16'h0100);
        pbuf[5] = ins(4'h9, 6, 7, 0);
        pbuf[6] = ins(4'hF, 0, 0, 0);
        load_prog(0, 7);
        we0 = we_cnt; oe0 = oe_cnt;
        run("st_ld");
        chk("st_erwe_cycles", we_cnt - we0, 1);
        chk("st_ea", we_ea, 13'h0ABC);
        chk("st_data", we_d, 16'hBEEF);
        chk("ld_eroe_cycles", oe_cnt - oe0, 4);
        chk("ld_r4", dut.regs[4], 16'hBEEF);
        chk("ld_r6", dut.regs[6], 16'h5A5A);

        pbuf[0] = ins(4'h6, 0, 0, 0);
        pbuf[1] = ins(4'hF, 0, 0, 0);
        load_prog(0, 2);
        run("wrap_prep");
        pbuf[0] = ins(4'hC, 0, 0, 16'd61);
        pbuf[1] = ins(4'hF, 0, 0, 0);
        load_prog(0, 2);
        pbuf[0] = ins(4'h1, 2, 0, 16'h0001);
        pbuf[1] = ins(4'h5, 2, 2, 0);
        pbuf[2] = ins(4'h0, 0, 0, 16'h8000);
        load_prog(61, 3);
        run("wrap");
        chk("wrap_busy_cycles", bcnt, 12);
        chk("wrap_out0_nop", out0_halt, 0);
        chk("wrap_out0_idle", out0, 1);

        pbuf[0] = ins(4'h1, 1, 0, 0);
        for (int i = 1; i < 6; i++) pbuf[i] = ins(4'hD, 0, 0, 16'(i + 1));
        pbuf[6] = ins(4'h1, 1, 0, 16'h00AA);
        pbuf[7] = ins(4'hF, 0, 0, 0);
        load_prog(0, 8);
        run("call");
`ifdef PMC2_CALLSTACK_EN
        chk("call_busy_cycles", bcnt, 12);
        chk("call_err", err, 1);
        chk("call_r1", dut.regs[1], 0);
`else
        chk("call_busy_cycles", bcnt, 16);
        chk("call_err", err, 0);
        chk("call_r1", dut.regs[1], 16'h00AA);
`endif

        pbuf[0] = ins(4'h0, 0, 0, 16'h8000);
        pbuf[1] = ins(4'h1, 4, 0, 16'h1111);
        pbuf[2] = ins(4'h1, 5, 0, 16'h0100);
        pbuf[3] = ins(4'h9, 4, 5, 0);
        pbuf[4] = ins(4'hF, 0, 0, 0);
        load_prog(0, 5);
        start = 1; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            host_we = 1; host_sel = 1; host_d = 8'hFF;
            if (!eroe) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL abort_wait: eroe never went low, got %b want 0", eroe);
        end
        @(negedge clk);
        chk("abort_memrd_eroe", eroe, 0);
        chk("abort_memrd_out0", out0, 0);
        start = 0; host_we = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_eroe", eroe, 1);
        chk("abort_out0", out0, 1);
        chk("abort_r4", dut.regs[4], 16'h1111);
        chk("busy_host_ram5", dut.ram[5], ins(4'hD, 0, 0, 16'd6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pmc2_core.md
PMC2_CORE -- requirements
Module: pmc2_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with all sequential logic on the rising edge of pin_M12.
REQ-002 Parameter DATA_W, default 16, SHALL set register/ALU/external data width (8..16).
REQ-003 Parameter PROG_DEPTH, default 64, SHALL set program RAM words (power of 2, 16..256); PC_W = log2(PROG_DEPTH).
REQ-004 Parameter NREGS, default 8, SHALL set the general register count (2..8).
REQ-005 Parameter EA_W, default 13, SHALL set external address width.
REQ-006 Parameter STACK_DEPTH, default 4, SHALL set call stack entries (1..16).
REQ-007 Port pin_M12, input, 1: clock.
REQ-008 Port pin_RST, input, 1: async active-low reset.
REQ-009 Port host_we, input, 1: host write strobe, one byte per cycle.
REQ-010 Port host_sel, input, 1: 0 = set load pointer LD, 1 = program data byte.
REQ-011 Port host_d, input, 8: host data.
REQ-012 Port pin_START, input, 1: run enable, level.
REQ-013 Port pin_BUSY, output, 1: high while executing.
REQ-014 Port pin_ERR, output, 1: sticky stack fault.
REQ-015 Port pin_OUT0, output, 1: program-controlled output.
REQ-016 Port pin_EA, output, EA_W: external RAM address.
REQ-017 Ports pin_ED_I (input, DATA_W) and pin_ED_O (output, DATA_W): external data.
REQ-018 Ports pin_EROE and pin_ERWE, outputs, 1: active-low external read/write strobes.

Function
REQ-019 Program load: host_sel=0 write SHALL set LD=host_d[PC_W-1:0] and clear byte counter.
REQ-020 host_sel=1 writes SHALL assemble a 36-bit word, byte0 -> [35:32] (low nibble), bytes1..4 -> [31:24],[23:16],[15:8],[7:0]; the 5th byte SHALL write RAM[LD], then LD+1 (wrap PROG_DEPTH-1 -> 0) and clear the counter.
REQ-021 Host writes while pin_BUSY=1 SHALL be ignored.
REQ-022 Word fields SHALL be: op [35:32], rd [31:29], rs [28:26], imm [15:0]; registers SHALL take imm[DATA_W-1:0].
REQ-023 FSM states IDLE, FETCH, EXEC, MEMRD, HALT; IDLE->FETCH on pin_START rising edge with PC=0; FETCH->EXEC always; EXEC->FETCH except op LD (->MEMRD, one cycle, ->FETCH) and HALT (->HALT).
REQ-024 pin_START low in any state SHALL force IDLE next cycle, abandon the instruction, keep registers, and drive pin_OUT0=1.
REQ-025 pin_BUSY SHALL be 1 in FETCH/EXEC/MEMRD, 0 in IDLE/HALT; HALT SHALL exit to IDLE only when pin_START falls.
REQ-026 Ops: 0 NOP (imm[15]=1 -> pin_OUT0<=imm[0]); 1 LDI rd=imm; 2 ADD rd+=rs; 3 SUB rd-=rs; 4 AND; 5 OR; 6 XOR; 7 SHR rd>>1 with C into MSB; 8 SHL rd<<1 with C into LSB; 9 LD rd=ED; A ST ED=rd; B JMP; C JZ; D CALL; E RET; F HALT.
REQ-027 ALU results SHALL wrap modulo 2^DATA_W; Z = result zero; C = carry out (ADD), no-borrow (SUB), shifted-out bit (SHR/SHL); logic ops clear C; flags SHALL update only on ops 2..8.
REQ-028 Branch target SHALL be imm[PC_W-1:0]; non-branch PC SHALL increment with wrap to 0.
REQ-029 LD/ST address SHALL be rs[EA_W-1:0] zero-extended; pin_EROE low in LD's EXEC and MEMRD, data sampled end of MEMRD; pin_ERWE low for ST's EXEC cycle only, pin_ED_O=rd.
REQ-030 Register index >= NREGS SHALL read 0; writes to it SHALL be dropped.

Reset
REQ-031 Reset SHALL set: state IDLE, PC=0, LD=0, byte counter 0, registers/flags 0, stack pointer 0, pin_BUSY=0, pin_ERR=0, pin_OUT0=1, pin_EROE=pin_ERWE=1, pin_EA=0, pin_ED_O=0; program RAM unchanged.

Configuration
REQ-032 With PMC2_CALLSTACK_EN defined, CALL SHALL push PC+1 and jump, RET SHALL pop; push when full or pop when empty SHALL set pin_ERR=1 and enter HALT.
REQ-033 Without PMC2_CALLSTACK_EN, CALL/RET SHALL execute as NOP, no stack storage SHALL exist, and pin_ERR SHALL be tied 0.

Verification
REQ-034 Load LD=0 then LDI r1,0x1234 / HALT; raise START -> r1=0x1234, BUSY high exactly 4 cycles.
REQ-035 r1=0xFFFF, r2=1, ADD r1,r2 -> r1=0x0000, Z=1, C=1; SUB 0x0000-0x0001 -> 0xFFFF, C=0.
REQ-036 ST r3->addr 0x0ABC, then LD -> ERWE low 1 cycle with EA=0x0ABC; EROE low 2 cycles; r4 = model value.
REQ-037 Instruction at PROG_DEPTH-1 is NOP, word 0 is HALT -> PC wraps to 0, enters HALT.
REQ-038 With macro: CALL nested STACK_DEPTH+1 deep -> ERR=1, HALT; without: same program runs CALLs as NOP.
REQ-039 Drop START mid-LD (MEMRD) -> IDLE next cycle, EROE=1, OUT0=1; host writes during BUSY leave RAM unchanged.
